// File: rtl/fp_pkg.sv
// Shared types for the fixed-point operation sequencer: opcodes, FSM states and
// the queued request record.
package fp_pkg;

    localparam int REQ_W = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic [REQ_W-1:0] a;
        logic [REQ_W-1:0] b;
        logic [1:0]       op;
    } req_t;

endpackage

// File: rtl/fp_op_sequencer_if.sv
// Request, arithmetic-unit and response signals of the operation sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface fp_op_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic [WIDTH-1:0]           req_a;
    logic [WIDTH-1:0]           req_b;
    logic [1:0]                 req_op;
    logic [WIDTH-1:0]           alu_a;
    logic [WIDTH-1:0]           alu_b;
    logic [1:0]                 alu_opcode;
    logic                       alu_start;
    logic                       alu_done;
    logic [WIDTH-1:0]           alu_result;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [WIDTH-1:0]           rsp_data;
    logic [1:0]                 rsp_op;
    logic                       rsp_err;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_done, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_opcode, alu_start,
               rsp_valid, rsp_data, rsp_op, rsp_err, occupancy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_done, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_opcode, alu_start,
               rsp_valid, rsp_data, rsp_op, rsp_err, occupancy
    );
endinterface

// File: rtl/fp_req_fifo.sv
// Synchronous request FIFO with entry count; pointers wrap naturally because
// DEPTH is a power of two.
module fp_req_fifo
    import fp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  req_t                       din,
    output req_t                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == OW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign dout      = mem[rd_ptr];
    assign occupancy = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fp_op_sequencer.sv
// Issue stage for the fixed-point arithmetic unit: queues requests, issues them
// one at a time, waits for done or timeout, and returns in-order responses.
module fp_op_sequencer
    import fp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst_n,
    fp_op_sequencer_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_e           state;
    state_e           state_nxt;
    req_t             push_req;
    req_t             head;
    logic             full;
    logic             empty;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;
    logic [1:0]       cur_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_opcode;
    logic             alu_start;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       rsp_op;
    logic             rsp_err;

    assign push_req = '{a: REQ_W'(bus.req_a), b: REQ_W'(bus.req_b), op: bus.req_op};

    fp_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.req_valid),
        .pop       (pop),
        .din       (push_req),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occ)
    );

    assign timed_out = (cnt == CNT_W'(TIMEOUT-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Reserved opcodes are resolved in ISSUE so the unit never sees a start.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_op == OP_RSV) begin
                    state_nxt = RESP;
                end else begin
                    alu_start = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.alu_done || timed_out) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_op     <= OP_ADD;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= OP_ADD;
            cnt        <= '0;
            rsp_data   <= '0;
            rsp_op     <= OP_ADD;
            rsp_err    <= 1'b0;
        end else begin
            if (pop) begin
                cur_op <= head.op;
                if (head.op != OP_RSV) begin
                    alu_a      <= WIDTH'(head.a);
                    alu_b      <= WIDTH'(head.b);
                    alu_opcode <= head.op;
                end
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + CNT_W'(1);
            if (state == ISSUE && cur_op == OP_RSV) begin
                rsp_data <= '0;
                rsp_op   <= cur_op;
                rsp_err  <= 1'b1;
            end
            // A done arriving in the final WAIT cycle still wins over timeout.
            if (state == WAIT) begin
                if (bus.alu_done) begin
                    rsp_data <= bus.alu_result;
                    rsp_op   <= cur_op;
                    rsp_err  <= 1'b0;
                end else if (timed_out) begin
                    rsp_data <= '0;
                    rsp_op   <= cur_op;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready  = !full;
    assign bus.occupancy  = occ;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_opcode = alu_opcode;
    assign bus.alu_start  = alu_start;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_op     = rsp_op;
    assign bus.rsp_err    = rsp_err;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Bench for fp_op_sequencer: a latency-programmable arithmetic unit stand-in and
// an in-order response model built from request order, opcode and unit latency.
module tb_fp_op_sequencer;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   op;
        logic         err;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   starts = 0;
    rsp_t exp_q[$];
    rsp_t got_q[$];
    int   got_cyc[$];
    int   lat_q[$];
    bit           alu_busy = 1'b0;
    int           alu_rem  = 0;
    logic [W-1:0] alu_la, alu_lb;
    logic [1:0]   alu_lop;

    fp_op_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus ();

    fp_op_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a * b;
            default: return (b == '0) ? '1 : a / b;
        endcase
    endfunction

    // A unit answering d cycles after start succeeds only when d fits in the wait window.
    function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input int lat);
        rsp_t r;
        r.op   = op;
        r.data = '0;
        r.err  = 1'b1;
        if (op != 2'b11 && lat >= 1 && lat <= TO) begin
            r.data = alu_f(a, b, op);
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // Arithmetic unit stand-in; latency 0 means it never answers.
    always @(negedge clk) begin
        #1;
        bus.alu_done   = 1'b0;
        bus.alu_result = $urandom;
        if (!rst_n) begin
            alu_busy = 1'b0;
            lat_q.delete();
        end else begin
            if (alu_busy && alu_rem > 0) begin
                alu_rem--;
                if (alu_rem == 0) begin
                    bus.alu_done   = 1'b1;
                    bus.alu_result = alu_f(alu_la, alu_lb, alu_lop);
                    alu_busy       = 1'b0;
                end
            end
            if (bus.alu_start) begin
                starts++;
                alu_busy = 1'b1;
                alu_la   = bus.alu_a;
                alu_lb   = bus.alu_b;
                alu_lop  = bus.alu_opcode;
                alu_rem  = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            got_q.push_back('{bus.rsp_data, bus.rsp_op, bus.rsp_err});
            got_cyc.push_back(cyc);
        end
    end

    // Presents one request for one cycle, starting and ending at a falling edge.
    task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] op, input int lat, output bit acc);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        acc = bus.req_ready;
        if (acc) begin
            exp_q.push_back(model(a, b, op, lat));
            if (op != 2'b11) lat_q.push_back(lat);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] obs [10];
        string nm [10] = '{"req_ready", "occupancy", "alu_start", "alu_a", "alu_b",
                           "alu_opcode", "rsp_valid", "rsp_data", "rsp_op", "rsp_err"};
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        obs = '{W'(bus.req_ready), W'(bus.occupancy), W'(bus.alu_start), bus.alu_a, bus.alu_b,
                W'(bus.alu_opcode), W'(bus.rsp_valid), bus.rsp_data, W'(bus.rsp_op), W'(bus.rsp_err)};
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== ((i == 0) ? W'(1) : W'(0))) begin
                errors++;
                $display("FAIL reset_%s: got %h expected %h", nm[i], obs[i], (i == 0) ? 1 : 0);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        bit acc;
        int k = -1, st = -1;
        bus.rsp_ready = 1'b1;
        drive_req(32'h0080_0000, 32'h0080_0000, 2'b00, 1, acc);
        for (int i = 0; i < 12; i++) begin
            if (st < 0 && bus.alu_start) st = i;
            if (bus.rsp_valid) begin k = i; break; end
            @(negedge clk);
        end
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL lat_accept: got %0b expected 1", acc); end
        checks++; if (st != 1) begin errors++; $display("FAIL lat_start_cycle: got %0d expected 1", st); end
        checks++; if (k != 3) begin errors++; $display("FAIL lat_rsp_cycle: got %0d expected 3", k); end
        checks++; if (bus.rsp_data !== 32'h0100_0000) begin errors++; $display("FAIL lat_data: got %h expected 01000000", bus.rsp_data); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL lat_err: got %b expected 0", bus.rsp_err); end
        for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL lat_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            rsp_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL lat_rsp: got %h expected %h", g, e); end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_fill();
        bit acc;
        int occ_exp [5] = '{1, 1, 2, 3, 4};
        int s0 = starts;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_req($urandom, $urandom, 2'($urandom_range(0, 2)), 6, acc);
            checks++;
            if (!acc || bus.occupancy !== 3'(occ_exp[i])) begin
                errors++;
                $display("FAIL fill_occ%0d: got acc=%0b occ=%0d expected acc=1 occ=%0d", i, acc, bus.occupancy, occ_exp[i]);
            end
        end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", bus.req_ready); end
        drive_req($urandom, $urandom, 2'b00, 1, acc);
        checks++; if (acc !== 1'b0 || bus.occupancy !== 3'd4) begin errors++; $display("FAIL fill_refuse: got acc=%0b occ=%0d expected acc=0 occ=4", acc, bus.occupancy); end
        repeat (12) @(negedge clk);
        checks++; if (starts - s0 != 1) begin errors++; $display("FAIL fill_starts: got %0d expected 1", starts - s0); end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            rsp_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL fill_rsp: got %h expected %h", g, e); end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_reserved();
        bit acc;
        int k = -1;
        int s0 = starts;
        bus.rsp_ready = 1'b1;
        drive_req($urandom, $urandom, 2'b11, 1, acc);
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid) begin k = i; break; end
            @(negedge clk);
        end
        checks++; if (k != 2) begin errors++; $display("FAIL rsv_rsp_cycle: got %0d expected 2", k); end
        checks++;
        if ({bus.rsp_data, bus.rsp_op, bus.rsp_err} !== {32'h0, 2'b11, 1'b1}) begin
            errors++;
            $display("FAIL rsv_fields: got data=%h op=%b err=%b expected data=0 op=11 err=1", bus.rsp_data, bus.rsp_op, bus.rsp_err);
        end
        repeat (4) @(negedge clk);
        checks++; if (starts != s0) begin errors++; $display("FAIL rsv_no_start: got %0d starts expected 0", starts - s0); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rsv_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            rsp_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL rsv_rsp: got %h expected %h", g, e); end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_timeout();
        bit acc;
        int k = -1;
        bit st0;
        bus.rsp_ready = 1'b1;
        drive_req($urandom, $urandom, 2'b01, 0, acc);
        drive_req(32'd1000, 32'd24, 2'b00, 3, acc);
        st0 = bus.alu_start;
        for (int i = 0; i < 3 * TO; i++) begin
            if (bus.rsp_valid) begin k = i; break; end
            @(negedge clk);
        end
        checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL to_start: got %b expected 1", st0); end
        checks++; if (k != TO + 1) begin errors++; $display("FAIL to_wait_len: got %0d expected %0d", k, TO + 1); end
        for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL to_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            rsp_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL to_rsp: got %h expected %h", g, e); end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_resp_stall();
        bit acc;
        int k = -1;
        logic [W+2:0] snap;
        bus.rsp_ready = 1'b0;
        drive_req($urandom, $urandom, 2'b10, 1, acc);
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) begin k = i; break; end
            @(negedge clk);
        end
        checks++; if (k < 0) begin errors++; $display("FAIL stall_rsp_timeout: got none expected rsp_valid"); end
        snap = {bus.rsp_data, bus.rsp_op, bus.rsp_err};
        for (int i = 0; i < 5; i++) begin
            drive_req($urandom, $urandom, 2'($urandom_range(0, 2)), $urandom_range(1, 8), acc);
            checks++;
            if (acc !== (i < 4)) begin errors++; $display("FAIL stall_push%0d: got %0b expected %0b", i, acc, i < 4); end
            checks++;
            if ({bus.rsp_valid, bus.alu_start, bus.rsp_data, bus.rsp_op, bus.rsp_err} !== {2'b10, snap}) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h expected %h", i,
                         {bus.rsp_valid, bus.alu_start, bus.rsp_data, bus.rsp_op, bus.rsp_err}, {2'b10, snap});
            end
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            rsp_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL stall_rsp: got %h expected %h", g, e); end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_back_to_back();
        bit acc;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive_req($urandom, $urandom, 2'($urandom_range(0, 2)), 1, acc);
        for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", got_q.size()); end
        for (int i = 1; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] != 4) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 4", i, got_cyc[i] - got_cyc[i-1]); end
        end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            rsp_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_rsp: got %h expected %h", g, e); end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_rst_mid();
        bit acc;
        logic [W-1:0] obs [10];
        string nm [10] = '{"req_ready", "occupancy", "alu_start", "alu_a", "alu_b",
                           "alu_opcode", "rsp_valid", "rsp_data", "rsp_op", "rsp_err"};
        int s0 = starts;
        bus.rsp_ready = 1'b1;
        drive_req(32'hdead_beef, 32'h1234_5678, 2'b01, 0, acc);
        drive_req($urandom, $urandom, 2'b00, 1, acc);
        drive_req($urandom, $urandom, 2'b10, 1, acc);
        checks++; if (bus.occupancy !== 3'd2) begin errors++; $display("FAIL rstmid_pre_occ: got %0d expected 2", bus.occupancy); end
        rst_n = 1'b0;
        #1;
        obs = '{W'(bus.req_ready), W'(bus.occupancy), W'(bus.alu_start), bus.alu_a, bus.alu_b,
                W'(bus.alu_opcode), W'(bus.rsp_valid), bus.rsp_data, W'(bus.rsp_op), W'(bus.rsp_err)};
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== ((i == 0) ? W'(1) : W'(0))) begin
                errors++;
                $display("FAIL rstmid_%s: got %h expected %h", nm[i], obs[i], (i == 0) ? 1 : 0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d expected 0", got_q.size()); end
        checks++; if (starts - s0 != 1) begin errors++; $display("FAIL rstmid_starts: got %0d expected 1", starts - s0); end
        got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_random();
        bit acc;
        int pushed = 0;
        for (int t = 0; t < 3000 && pushed < 40; t++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                drive_req($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(1, 10), acc);
                if (acc) pushed++;
            end else begin
                @(negedge clk);
            end
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 1000 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size() || pushed != 40) begin
            errors++;
            $display("FAIL rand_count: got %0d responses of %0d pushed expected %0d of 40", got_q.size(), pushed, exp_q.size());
        end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            rsp_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL rand_rsp: got %h expected %h", g, e); end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_reserved();
        test_timeout();
        test_resp_stall();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
